pwm_ramp_ctrl: RTL and testbench
================================

// Module: pwm_ramp_ctrl
// PURPOSE
//  Soft-start / slew-rate controller for the motor PWM datapath. Takes a raw 7-bit duty request
//  (onboard switches) and walks the PWM compare value toward it in bounded steps, only at PWM
//  period boundaries. Sits between the switch inputs and the PWM block's duty input. Also handles
//  enable ramp-down and an emergency-stop fault state.
// PARAMETERS
//  WIDTH            7    duty / compare width (must match PWM counter width)
//  STEP             4    duty increment/decrement per ramp step (1..2^WIDTH-1)
//  PERIODS_PER_STEP 2    PWM periods (E pulses) between ramp steps (1..256)
//  MAX_DUTY         127  ceiling applied to TARGET
// PORTS
//  CLK       in   1      system clock; all state updates on posedge
//  RST       in   1      asynchronous, active-high reset
//  E         in   1      period-boundary strobe from timer/counter, 1 CLK wide, once per period
//  EN        in   1      run request; 0 = ramp duty down to 0
//  ESTOP     in   1      emergency stop, level, highest priority
//  TARGET    in   WIDTH  requested duty (switches); may change any cycle
//  DUTY      out  WIDTH  registered compare value driven to the PWM block
//  STATE     out  2      0=IDLE 1=RAMP 2=HOLD 3=FAULT
//  AT_TARGET out  1      1 while in HOLD
//  BUSY      out  1      1 while in RAMP
// BEHAVIOUR
//  Reset (async, RST=1): DUTY=0, STATE=IDLE, AT_TARGET=0, BUSY=0, period divider=0. Reset mid-ramp
//   abandons the ramp immediately; no ramp-down.
//  Effective target T = ESTOP ? 0 : EN ? min(TARGET, MAX_DUTY) : 0, evaluated combinationally
//   every cycle.
//  Divider: counts E pulses while in RAMP, 0..PERIODS_PER_STEP-1. A step occurs on the posedge
//   where E=1 and divider==PERIODS_PER_STEP-1; divider then wraps to 0. Divider cleared on entry
//   to RAMP. DUTY never changes except on such a step edge, in FAULT entry, or on reset; DUTY is
//   therefore constant across each PWM period.
//  Step arithmetic: if DUTY<T then DUTY<=min(DUTY+STEP, T); if DUTY>T then DUTY<=max(DUTY-STEP, T).
//   Computed WIDTH+1 bits wide; no overflow, wrap or overshoot. Lands exactly on T.
//  FSM transitions (evaluated each posedge, first match wins):
//   any state, ESTOP=1 -> FAULT; DUTY<=0 on the same edge (no ramp, no wait for E).
//   FAULT  -> IDLE when ESTOP=0 and EN=0 (EN must be released to re-arm). Otherwise stay; DUTY=0.
//   IDLE   -> RAMP when T!=0 (DUTY is 0 in IDLE).
//   RAMP   -> HOLD on the step edge where the new DUTY==T and T!=0.
//   RAMP   -> IDLE on the step edge where the new DUTY==0 and T==0.
//   HOLD   -> RAMP when T!=DUTY (target moved or EN dropped); divider cleared.
//  Target changes during RAMP: direction follows the current T at each step; the divider is not
//   cleared, so the reversal takes effect at the next scheduled step.
//  T==DUTY while in RAMP between steps: no change until the next step edge, which then performs the
//   HOLD/IDLE transition with a zero-size step.
//  E and ESTOP on the same edge: ESTOP wins. E asserted while not in RAMP: ignored.
//  Latency: first DUTY change after EN rises is at the PERIODS_PER_STEP-th E pulse after entering
//   RAMP. Full 0->127 ramp = ceil(127/STEP) steps.
// TESTING
//  Conventions: E pulses every 128 CLK. Defaults unless noted.
//  1 Soft start: EN=1, TARGET=10 -> DUTY 0,4,8,10 after the 2nd, 4th and 6th E pulses;
//    STATE RAMP then HOLD; AT_TARGET=1.
//  2 Clamp: MAX_DUTY=100, TARGET=127, STEP=50 -> DUTY 50,100; HOLD at 100; never exceeds 100.
//  3 Ramp-down: from HOLD at 10, EN=0 -> DUTY 6,2,0 on successive step edges; STATE IDLE.
//    AT_TARGET=0 throughout.
//  4 Reversal: ramping up at DUTY=8, TARGET->2 -> next step gives DUTY=4, then 2; no overshoot.
//    HOLD at 2.
//  5 ESTOP: mid-ramp DUTY=8, ESTOP=1 with E=1 on the same edge -> DUTY=0, STATE=FAULT next edge.
//    ESTOP=0 with EN=1 stays FAULT; EN=0 -> IDLE.
//  6 Reset: RST pulse mid-ramp, asynchronous to CLK -> DUTY=0, STATE=IDLE immediately.
//    After release with EN=1, the ramp restarts from 0 with a fresh divider.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / slew-rate limiter for the PWM compare value. It steps DUTY toward the
// effective target only on period-boundary strobes, and it forces DUTY to 0 when ESTOP is asserted.
module pwm_ramp_ctrl #(
    parameter int WIDTH            = 7,
    parameter int STEP             = 4,
    parameter int PERIODS_PER_STEP = 2,
    parameter int MAX_DUTY         = 127
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             E,
    input  logic             EN,
    input  logic             ESTOP,
    input  logic [WIDTH-1:0] TARGET,
    output logic [WIDTH-1:0] DUTY,
    output logic [1:0]       STATE,
    output logic             AT_TARGET,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] DUTY_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] DUTY_CEIL = WIDTH'(MAX_DUTY);
    localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH+1)'(STEP);
    localparam logic [7:0]       DIV_LAST  = 8'(PERIODS_PER_STEP - 1);

    state_t           state_r;
    logic [WIDTH-1:0] duty_r;
    logic [7:0]       div_r;
    logic             at_target_r;
    logic             busy_r;

    logic [WIDTH-1:0] target_s;
    logic [WIDTH-1:0] next_duty_s;
    logic [WIDTH:0]   up_s;
    logic [WIDTH:0]   dn_s;

    // Effective target: stop and disable both collapse it to zero, otherwise clamp to the ceiling.
    always_comb begin
        target_s = DUTY_ZERO;
        if (ESTOP) begin
            target_s = DUTY_ZERO;
        end else if (EN) begin
            target_s = (TARGET > DUTY_CEIL) ? DUTY_CEIL : TARGET;
        end else begin
            target_s = DUTY_ZERO;
        end
    end

    // One bounded step toward the target, one bit wider so the limit compare never wraps.
    always_comb begin
        up_s        = {1'b0, duty_r} + STEP_EXT;
        dn_s        = {1'b0, duty_r} - STEP_EXT;
        next_duty_s = duty_r;
        if (duty_r < target_s) begin
            next_duty_s = (up_s > {1'b0, target_s}) ? target_s : up_s[WIDTH-1:0];
        end else if (duty_r > target_s) begin
            next_duty_s = (dn_s[WIDTH] || (dn_s[WIDTH-1:0] < target_s)) ? target_s : dn_s[WIDTH-1:0];
        end else begin
            next_duty_s = duty_r;
        end
    end

    // Control FSM; DUTY only moves on a step edge, on stop, or on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            duty_r      <= DUTY_ZERO;
            div_r       <= 8'd0;
            at_target_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (ESTOP) begin
            state_r     <= ST_FAULT;
            duty_r      <= DUTY_ZERO;
            div_r       <= 8'd0;
            at_target_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_FAULT: begin
                    duty_r <= DUTY_ZERO;
                    if (!EN) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (target_s != DUTY_ZERO) begin
                        state_r <= ST_RAMP;
                        div_r   <= 8'd0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (E) begin
                        if (div_r == DIV_LAST) begin
                            div_r  <= 8'd0;
                            duty_r <= next_duty_s;
                            if ((next_duty_s == target_s) && (target_s != DUTY_ZERO)) begin
                                state_r     <= ST_HOLD;
                                busy_r      <= 1'b0;
                                at_target_r <= 1'b1;
                            end else if ((next_duty_s == DUTY_ZERO) && (target_s == DUTY_ZERO)) begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            div_r <= div_r + 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (target_s != duty_r) begin
                        state_r     <= ST_RAMP;
                        div_r       <= 8'd0;
                        at_target_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    duty_r      <= DUTY_ZERO;
                    div_r       <= 8'd0;
                    at_target_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign DUTY      = duty_r;
    assign STATE     = state_r;
    assign AT_TARGET = at_target_r;
    assign BUSY      = busy_r;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl. It applies a vector table, hand-written reset and clamp sequences,
// and random stimulus, and compares two parameterisations against an arithmetic reference model.
module tb_pwm_ramp_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       E = 1'b0, EN = 1'b0, ESTOP = 1'b0;
    logic [6:0] TARGET = 7'd0;
    logic [6:0] duty1, duty2;
    logic [1:0] st1, st2;
    logic       at1, at2, busy1, busy2;

    int n_checks = 0;
    int n_err    = 0;

    pwm_ramp_ctrl dut (
        .CLK(CLK), .RST(RST), .E(E), .EN(EN), .ESTOP(ESTOP), .TARGET(TARGET),
        .DUTY(duty1), .STATE(st1), .AT_TARGET(at1), .BUSY(busy1)
    );

    pwm_ramp_ctrl #(.WIDTH(7), .STEP(50), .PERIODS_PER_STEP(1), .MAX_DUTY(100)) dut2 (
        .CLK(CLK), .RST(RST), .E(E), .EN(EN), .ESTOP(ESTOP), .TARGET(TARGET),
        .DUTY(duty2), .STATE(st2), .AT_TARGET(at2), .BUSY(busy2)
    );

    always #5 CLK = ~CLK;

    // Reference model: per instance, a duty value, a mode (0 idle,1 ramp,2 hold,3 fault)
    // and a count of E pulses seen since the ramp was entered.
    int p_step[2] = '{4, 50};
    int p_pps[2]  = '{2, 1};
    int p_max[2]  = '{127, 100};
    int m_duty[2], m_mode[2], m_cnt[2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_duty[i] = 0; m_mode[i] = 0; m_cnt[i] = 0;
        end
    endtask

    function automatic int eff_target(input int i);
        int t;
        if (ESTOP) return 0;
        if (!EN) return 0;
        t = int'(TARGET);
        return (t > p_max[i]) ? p_max[i] : t;
    endfunction

    task automatic model_step();
        int t, nd;
        for (int i = 0; i < 2; i++) begin
            t = eff_target(i);
            if (RST) begin
                m_duty[i] = 0; m_mode[i] = 0; m_cnt[i] = 0;
            end else if (ESTOP) begin
                m_duty[i] = 0; m_mode[i] = 3; m_cnt[i] = 0;
            end else if (m_mode[i] == 3) begin
                if (!EN) m_mode[i] = 0;
            end else if (m_mode[i] == 0) begin
                if (t != 0) begin m_mode[i] = 1; m_cnt[i] = 0; end
            end else if (m_mode[i] == 2) begin
                if (t != m_duty[i]) begin m_mode[i] = 1; m_cnt[i] = 0; end
            end else if (E) begin
                m_cnt[i]++;
                if (m_cnt[i] % p_pps[i] == 0) begin
                    nd = m_duty[i];
                    if (nd < t) nd = (nd + p_step[i] > t) ? t : nd + p_step[i];
                    else if (nd > t) nd = (nd - p_step[i] < t) ? t : nd - p_step[i];
                    m_duty[i] = nd;
                    if (nd == t && t != 0) m_mode[i] = 2;
                    else if (nd == 0 && t == 0) m_mode[i] = 0;
                end
            end
        end
    endtask

    // Advance one clock: model sees the inputs held across the edge, outputs sampled 1 after.
    task automatic cyc();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2 RST = 1'b1;
        #1;
        chk("async rst duty", int'(duty1), 0);
        chk("async rst state", int'(st1), 0);
        chk("async rst busy", int'(busy1), 0);
        model_reset();
        RST = 1'b0;
    endtask

    task automatic cmp_model();
        chk("model duty", int'(duty1), m_duty[0]);
        chk("model state", int'(st1), m_mode[0]);
        chk("model at", int'(at1), (m_mode[0] == 2) ? 1 : 0);
        chk("model busy", int'(busy1), (m_mode[0] == 1) ? 1 : 0);
        chk("model2 duty", int'(duty2), m_duty[1]);
        chk("model2 state", int'(st2), m_mode[1]);
        chk("model2 at", int'(at2), (m_mode[1] == 2) ? 1 : 0);
        chk("model2 busy", int'(busy2), (m_mode[1] == 1) ? 1 : 0);
        chk("clamp bound", (duty2 <= 7'd100) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic en, estop, e;
        logic [6:0] tgt;
        logic [6:0] duty;
        logic [1:0] st;
        logic at, busy;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic es, input logic e, input int tgt,
                                input int duty, input int st, input logic at, input logic busy);
        vec_t v;
        v.en = en; v.estop = es; v.e = e; v.tgt = 7'(tgt);
        v.duty = 7'(duty); v.st = 2'(st); v.at = at; v.busy = busy;
        return v;
    endfunction

    vec_t tbl[33];

    initial begin
        // soft start to 10, then ramp-down, reversal, stop/re-arm
        tbl[0]  = mk(1,0,0,10, 0,1,0,1);  tbl[1]  = mk(1,0,1,10, 0,1,0,1);
        tbl[2]  = mk(1,0,1,10, 4,1,0,1);  tbl[3]  = mk(1,0,0,10, 4,1,0,1);
        tbl[4]  = mk(1,0,1,10, 4,1,0,1);  tbl[5]  = mk(1,0,1,10, 8,1,0,1);
        tbl[6]  = mk(1,0,1,10, 8,1,0,1);  tbl[7]  = mk(1,0,1,10,10,2,1,0);
        tbl[8]  = mk(1,0,1,10,10,2,1,0);  tbl[9]  = mk(0,0,0,10,10,1,0,1);
        tbl[10] = mk(0,0,1,10,10,1,0,1);  tbl[11] = mk(0,0,1,10, 6,1,0,1);
        tbl[12] = mk(0,0,1,10, 6,1,0,1);  tbl[13] = mk(0,0,1,10, 2,1,0,1);
        tbl[14] = mk(0,0,1,10, 2,1,0,1);  tbl[15] = mk(0,0,1,10, 0,0,0,0);
        tbl[16] = mk(1,0,0,10, 0,1,0,1);  tbl[17] = mk(1,0,1,10, 0,1,0,1);
        tbl[18] = mk(1,0,1,10, 4,1,0,1);  tbl[19] = mk(1,0,1,10, 4,1,0,1);
        tbl[20] = mk(1,0,1,10, 8,1,0,1);  tbl[21] = mk(1,0,1, 2, 8,1,0,1);
        tbl[22] = mk(1,0,1, 2, 4,1,0,1);  tbl[23] = mk(1,0,1, 2, 4,1,0,1);
        tbl[24] = mk(1,0,1, 2, 2,2,1,0);  tbl[25] = mk(1,0,0,10, 2,1,0,1);
        tbl[26] = mk(1,0,1,10, 2,1,0,1);  tbl[27] = mk(1,0,1,10, 6,1,0,1);
        tbl[28] = mk(1,0,1,10, 6,1,0,1);  tbl[29] = mk(1,1,1,10, 0,3,0,0);
        tbl[30] = mk(1,0,0,10, 0,3,0,0);  tbl[31] = mk(0,0,0,10, 0,0,0,0);
        tbl[32] = mk(0,0,0,127,0,0,0,0);

        model_reset();
        cyc();
        cyc();
        chk("reset duty", int'(duty1), 0);
        chk("reset state", int'(st1), 0);
        chk("reset at", int'(at1), 0);
        chk("reset busy", int'(busy1), 0);
        RST = 1'b0;

        for (int i = 0; i < 33; i++) begin
            EN = tbl[i].en; ESTOP = tbl[i].estop; E = tbl[i].e; TARGET = tbl[i].tgt;
            cyc();
            chk($sformatf("vec%0d duty", i), int'(duty1), int'(tbl[i].duty));
            chk($sformatf("vec%0d state", i), int'(st1), int'(tbl[i].st));
            chk($sformatf("vec%0d at", i), int'(at1), int'(tbl[i].at));
            chk($sformatf("vec%0d busy", i), int'(busy1), int'(tbl[i].busy));
        end

        // reset mid-ramp, then restart from 0 with a fresh divider
        EN = 1'b1; TARGET = 7'd10; E = 1'b0;
        cyc();
        E = 1'b1;
        cyc();
        cyc();
        E = 1'b0;
        chk("pre-reset duty", int'(duty1), 4);
        pulse_reset();
        cyc();
        chk("restart state", int'(st1), 1);
        chk("restart duty", int'(duty1), 0);
        E = 1'b1;
        cyc();
        chk("restart 1st E duty", int'(duty1), 0);
        cyc();
        chk("restart 2nd E duty", int'(duty1), 4);
        E = 1'b0;

        // clamp on the 50-step / ceiling-100 instance
        pulse_reset();
        EN = 1'b1; TARGET = 7'd127;
        cyc();
        chk("clamp ramp state", int'(st2), 1);
        E = 1'b1;
        cyc();
        chk("clamp step1 duty", int'(duty2), 50);
        cyc();
        chk("clamp step2 duty", int'(duty2), 100);
        chk("clamp hold state", int'(st2), 2);
        chk("clamp at_target", int'(at2), 1);
        cyc();
        chk("clamp stays", int'(duty2), 100);
        E = 1'b0;

        // random phase against the reference model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 59) == 0) EN = ~EN;
            if (ESTOP) ESTOP = ($urandom_range(0, 3) != 0);
            else       ESTOP = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) TARGET = 7'($urandom_range(0, 127));
            E = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 799) == 0) pulse_reset();
            cyc();
            cmp_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
